// File: rtl/tone_scheduler_if.sv
// Bus between the register-write decoder / prescaler and the tone scheduler.
// The master drives tick and register writes; the slave returns tone bits and status.
interface tone_scheduler_if;
    logic       tick;
    logic       wr_en;
    logic [3:0] wr_addr;
    logic [7:0] wr_data;
    logic [2:0] tone_out;
    logic       busy;
    logic       overrun;

    modport master (
        output tick, wr_en, wr_addr, wr_data,
        input  tone_out, busy, overrun
    );

    modport slave (
        input  tick, wr_en, wr_addr, wr_data,
        output tone_out, busy, overrun
    );
endinterface

// File: rtl/tone_scheduler.sv
// Time-multiplexed A/B/C tone generator: one shared compare/increment swept across channels.
// Optional sticky dropped-tick flag enabled by defining TONE_SCHED_OVERRUN_EN.
module tone_scheduler #(
    parameter int unsigned COUNTER_BITS = 12,
    parameter int unsigned NUM_CHANNELS = 3
) (
    input logic               clk,
    input logic               rst_n,
    tone_scheduler_if.slave   bus_if
);

    localparam logic [1:0] LastSlot = 2'(NUM_CHANNELS - 1);

    typedef enum logic {StIdle, StSweep} fsm_e;

    fsm_e                    r_fsm, w_fsm_d;
    logic [1:0]              r_slot, w_slot_d;
    logic                    r_pending, w_pending_d;
    logic                    w_slot_en;

    logic [7:0]              r_fine   [NUM_CHANNELS];
    logic [3:0]              r_coarse [NUM_CHANNELS];
    logic [COUNTER_BITS-1:0] r_cnt    [NUM_CHANNELS];
    logic [NUM_CHANNELS-1:0] r_state;

    logic [COUNTER_BITS-1:0] w_cur_cnt;
    logic [COUNTER_BITS-1:0] w_cur_period;
    logic [COUNTER_BITS-1:0] w_next_cnt;
    logic                    w_hit;

    // Shared datapath: select the active slot's counter and period.
    always_comb begin
        w_cur_cnt    = '0;
        w_cur_period = '0;
        for (int ch = 0; ch < NUM_CHANNELS; ch++) begin
            if (r_slot == 2'(ch)) begin
                w_cur_cnt    = r_cnt[ch];
                w_cur_period = COUNTER_BITS'({r_coarse[ch], r_fine[ch]});
            end
        end
    end

    // Period 0 falls out naturally: counter >= 0 always, so it toggles every slot.
    assign w_hit      = (w_cur_cnt >= w_cur_period);
    assign w_next_cnt = w_hit ? COUNTER_BITS'(1) : w_cur_cnt + COUNTER_BITS'(1);

    always_comb begin
        w_fsm_d     = r_fsm;
        w_slot_d    = r_slot;
        w_pending_d = r_pending;
        w_slot_en   = 1'b0;
        unique case (r_fsm)
            StIdle: begin
                if (bus_if.tick) begin
                    w_fsm_d  = StSweep;
                    w_slot_d = 2'd0;
                end
            end
            StSweep: begin
                w_slot_en = 1'b1;
                if (r_slot == LastSlot) begin
                    w_slot_d    = 2'd0;
                    w_pending_d = 1'b0;
                    if (!(bus_if.tick || r_pending)) begin
                        w_fsm_d = StIdle;
                    end
                end else begin
                    w_slot_d = r_slot + 2'd1;
                    if (bus_if.tick) begin
                        w_pending_d = 1'b1;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fsm     <= StIdle;
            r_slot    <= 2'd0;
            r_pending <= 1'b0;
        end else begin
            r_fsm     <= w_fsm_d;
            r_slot    <= w_slot_d;
            r_pending <= w_pending_d;
        end
    end

    // Period file: even address = fine, odd = coarse (upper nibble dropped).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int ch = 0; ch < NUM_CHANNELS; ch++) begin
                r_fine[ch]   <= 8'd0;
                r_coarse[ch] <= 4'd0;
            end
        end else if (bus_if.wr_en) begin
            for (int ch = 0; ch < NUM_CHANNELS; ch++) begin
                if (bus_if.wr_addr == 4'(2 * ch)) begin
                    r_fine[ch] <= bus_if.wr_data;
                end
                if (bus_if.wr_addr == 4'(2 * ch + 1)) begin
                    r_coarse[ch] <= bus_if.wr_data[3:0];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int ch = 0; ch < NUM_CHANNELS; ch++) begin
                r_cnt[ch] <= COUNTER_BITS'(1);
            end
            r_state <= '0;
        end else if (w_slot_en) begin
            for (int ch = 0; ch < NUM_CHANNELS; ch++) begin
                if (r_slot == 2'(ch)) begin
                    r_cnt[ch] <= w_next_cnt;
                    if (w_hit) begin
                        r_state[ch] <= ~r_state[ch];
                    end
                end
            end
        end
    end

    assign bus_if.tone_out = r_state;
    assign bus_if.busy     = (r_fsm == StSweep);

`ifdef TONE_SCHED_OVERRUN_EN
    logic r_overrun;
    logic w_drop;

    assign w_drop = (r_fsm == StSweep) && (r_slot != LastSlot) && bus_if.tick && r_pending;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_overrun <= 1'b0;
        end else if (w_drop) begin
            r_overrun <= 1'b1;
        end else if (bus_if.wr_en && (bus_if.wr_addr == 4'hF)) begin
            r_overrun <= 1'b0;
        end
    end

    assign bus_if.overrun = r_overrun;
`else
    assign bus_if.overrun = 1'b0;
`endif

endmodule
